// File: rtl/alu_mc.sv
// Registered multi-cycle ALU: one-cycle arithmetic/logic/shift ops plus an
// iterative shift-add unsigned multiply and a restoring unsigned divide,
// both behind a start/busy/done handshake.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic [WIDTH-1:0] ReadData2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_LUI  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_MULU = 4'b1011;
  localparam logic [3:0] OP_DIVU = 4'b1100;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   opb_q, opb_d;     // multiplicand or divisor
  logic [2*WIDTH-1:0] acc_q, acc_d;     // {hi,lo} product or {rem,quo}
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic               zero_q, zero_d;
  logic               overflow_q, overflow_d;
  logic               div_zero_q, div_zero_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   sc_res, sum, dif;
  logic               sc_ovf;
  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     mul_sum, div_trial, div_sub;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt;

  // single-cycle datapath, evaluated straight from the request operands
  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    shamt  = ReadData2[SHW-1:0];
    sum    = ReadData1 + ReadData2;
    dif    = ReadData1 - ReadData2;
    case (ALUOp)
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (ReadData1[WIDTH-1] == ReadData2[WIDTH-1]) &&
                 (sum[WIDTH-1] != ReadData1[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = dif;
        sc_ovf = (ReadData1[WIDTH-1] != ReadData2[WIDTH-1]) &&
                 (dif[WIDTH-1] != ReadData1[WIDTH-1]);
      end
      OP_AND:  sc_res = ReadData1 & ReadData2;
      OP_OR:   sc_res = ReadData1 | ReadData2;
      OP_LUI:  sc_res = ReadData2 << (WIDTH / 2);
      OP_XOR:  sc_res = ReadData1 ^ ReadData2;
      OP_SLL:  sc_res = ReadData1 << shamt;
      OP_SRL:  sc_res = ReadData1 >> shamt;
      OP_SRA:  sc_res = $signed(ReadData1) >>> shamt;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(ReadData1) < $signed(ReadData2)};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, ReadData1 < ReadData2};
      default: sc_res = '0;
    endcase
  end

  // one multiply step (add-if-LSB then shift right, carry into top) and one
  // restoring divide step (shift in next dividend bit, subtract if it fits)
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_nxt   = {mul_sum, acc_q[WIDTH-1:1]};
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_sub   = div_trial - {1'b0, opb_q};
    if (!div_sub[WIDTH])
      div_nxt = {div_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      div_nxt = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  end

  // next-state / result-register logic; outputs hold unless an op completes
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opb_d       = opb_q;
    acc_d       = acc_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    div_zero_d  = div_zero_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (ALUOp == OP_MULU) begin
            opb_d   = ReadData1;
            acc_d   = {{WIDTH{1'b0}}, ReadData2};
            cnt_d   = CW'(WIDTH);
            state_d = MUL;
          end else if (ALUOp == OP_DIVU && ReadData2 != '0) begin
            opb_d   = ReadData2;
            acc_d   = {{WIDTH{1'b0}}, ReadData1};
            cnt_d   = CW'(WIDTH);
            state_d = DIV;
          end else if (ALUOp == OP_DIVU) begin
            // divide by zero resolves immediately without iterating
            result_d    = '1;
            result_hi_d = ReadData1;
            zero_d      = 1'b0;
            overflow_d  = 1'b0;
            div_zero_d  = 1'b1;
            done_d      = 1'b1;
          end else begin
            result_d    = sc_res;
            result_hi_d = '0;
            zero_d      = (sc_res == '0);
            overflow_d  = sc_ovf;
            div_zero_d  = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        acc_d = (state_q == MUL) ? mul_nxt : div_nxt;
        cnt_d = cnt_q - CW'(1);
        // last step: publish the freshly computed accumulator directly
        if (cnt_q == CW'(1)) begin
          result_d    = acc_d[WIDTH-1:0];
          result_hi_d = acc_d[2*WIDTH-1:WIDTH];
          zero_d      = (acc_d[WIDTH-1:0] == '0);
          overflow_d  = 1'b0;
          div_zero_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and result registers; reset aborts any iteration in flight
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      opb_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b1;
      overflow_q  <= 1'b0;
      div_zero_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opb_q       <= opb_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      div_zero_q  <= div_zero_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign div_zero  = div_zero_q;
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=32): directed steps from the test plan followed by
// random ops, all checked against a plain-arithmetic reference model.
module tb_alu_mc;
  logic        CLK, Reset, start;
  logic [3:0]  ALUOp;
  logic [31:0] ReadData1, ReadData2;
  logic        busy, done, zero, overflow, div_zero;
  logic [31:0] result, result_hi;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] prev_res;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    logic        ov;
    logic        dz;
  } exp_t;

  alu_mc #(.WIDTH(32)) dut (
    .CLK(CLK), .Reset(Reset), .start(start), .ALUOp(ALUOp),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .zero(zero), .overflow(overflow), .div_zero(div_zero)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // reference: exact integer arithmetic, wrapped to 32 bits afterwards
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb, s;
    logic [63:0] p;
    logic [4:0] sh;
    e  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = b[4:0];
    case (op)
      4'd0:  begin s = sa + sb; e.res = 32'(s); e.ov = (s != longint'($signed(e.res))); end
      4'd1:  begin s = sa - sb; e.res = 32'(s); e.ov = (s != longint'($signed(e.res))); end
      4'd2:  e.res = a & b;
      4'd3:  e.res = a | b;
      4'd4:  e.res = b * 32'd65536;
      4'd5:  e.res = a ^ b;
      4'd6:  e.res = a << sh;
      4'd7:  e.res = a >> sh;
      4'd8:  e.res = 32'(sa / (longint'(1) << sh) - ((sa < 0 && (sa % (longint'(1) << sh)) != 0) ? 1 : 0));
      4'd9:  e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd10: e.res = (a < b) ? 32'd1 : 32'd0;
      4'd11: begin p = {32'd0, a} * {32'd0, b}; e.res = p[31:0]; e.hi = p[63:32]; end
      4'd12: begin
        if (b == 0) begin e.res = 32'hFFFFFFFF; e.hi = a; e.dz = 1'b1; end
        else begin e.res = a / b; e.hi = a % b; end
      end
      default: e.res = '0;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // issue one op, wait (bounded) for done, then check latency, busy span,
  // result fields and that done drops again; optionally pokes start mid-busy
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit poke);
    exp_t e;
    int lat, bcnt, exp_lat;
    bit iter;
    e       = model(op, a, b);
    iter    = (op == 4'd11) || (op == 4'd12 && b != 0);
    exp_lat = iter ? 33 : 1;
    @(negedge CLK);
    start = 1'b1; ALUOp = op; ReadData1 = a; ReadData2 = b;
    @(negedge CLK);
    start = 1'b0;
    lat = 1; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      if (lat == 1 && busy) chk({tag, ".hold"}, {32'd0, result}, {32'd0, prev_res});
      if (poke && lat == 3) begin
        start = 1'b1; ALUOp = 4'd0; ReadData1 = 32'd1; ReadData2 = 32'd1;
      end else if (poke && lat == 4) begin
        start = 1'b0;
      end
      @(negedge CLK);
      lat++;
    end
    chk({tag, ".lat"},  64'(lat), 64'(exp_lat));
    chk({tag, ".busyn"}, 64'(bcnt), iter ? 64'd32 : 64'd0);
    chk({tag, ".res"},  {32'd0, result}, {32'd0, e.res});
    chk({tag, ".hi"},   {32'd0, result_hi}, {32'd0, e.hi});
    chk({tag, ".flags"}, {61'd0, zero, overflow, div_zero}, {61'd0, e.z, e.ov, e.dz});
    prev_res = e.res;
    @(negedge CLK);
    chk({tag, ".pulse"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    int seen;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    Reset = 1'b0; start = 1'b0; ALUOp = '0; ReadData1 = '0; ReadData2 = '0;
    prev_res = '0;
    repeat (2) @(negedge CLK);
    chk("rst.state", {32'd0, result, result_hi == 0, busy, done, zero, overflow, div_zero} >> 0,
        {32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    Reset = 1'b1;

    // reset in the middle of a multiply
    @(negedge CLK);
    start = 1'b1; ALUOp = 4'd11; ReadData1 = 32'd3; ReadData2 = 32'd5;
    @(negedge CLK);
    start = 1'b0;
    repeat (5) @(negedge CLK);
    #2 Reset = 1'b0;
    #1 chk("midrst.out", {26'd0, result, busy, done, zero, overflow, div_zero},
           {26'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    @(negedge CLK);
    Reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge CLK);
      if (done || busy) seen++;
    end
    chk("midrst.nodone", 64'(seen), 64'd0);
    prev_res = '0;
    run_op("add5_7", 4'd0, 32'd5, 32'd7, 1'b0);

    // back-to-back add/sub
    @(negedge CLK);
    start = 1'b1; ALUOp = 4'd0; ReadData1 = 32'h7FFFFFFF; ReadData2 = 32'd1;
    @(negedge CLK);
    chk("b2b.add", {29'd0, result, done, overflow, zero}, {29'd0, 32'h80000000, 1'b1, 1'b1, 1'b0});
    ALUOp = 4'd1; ReadData1 = 32'd3; ReadData2 = 32'd3;
    @(negedge CLK);
    start = 1'b0;
    chk("b2b.sub", {29'd0, result, done, overflow, zero}, {29'd0, 32'd0, 1'b1, 1'b0, 1'b1});
    @(negedge CLK);
    chk("b2b.idle", {62'd0, done, busy}, 64'd0);
    prev_res = '0;

    run_op("sra",    4'd8,  32'h80000000, 32'h24, 1'b0);
    run_op("slt",    4'd9,  32'hFFFFFFFF, 32'd1,  1'b0);
    run_op("sltu",   4'd10, 32'hFFFFFFFF, 32'd1,  1'b0);
    run_op("lui",    4'd4,  32'hDEAD,     32'h1234, 1'b0);
    run_op("mulmax", 4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    run_op("div",    4'd12, 32'd100,      32'd7,  1'b0);
    run_op("div0",   4'd12, 32'd100,      32'd0,  1'b0);
    run_op("rsvd",   4'd15, 32'h1234,     32'h5678, 1'b0);
    run_op("subov",  4'd1,  32'h80000000, 32'd1,  1'b0);

    // random traffic
    for (int i = 0; i < 50; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 40));
      if ($urandom_range(0, 7) == 0) ra = 32'($urandom_range(0, 300));
      run_op("rnd", rop, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
